instr_issue_sequencer: RTL

//  Batch controller in front of the instruction buffer. Fills buffer entries from fetch in arrival order, then drains them
//  in the order given by the external mapping table. Drains through a valid/ready issue port. Sits between fetch, mapping table and issue stage.

---
 rtl/instr_seq_pkg.sv | 6 +
 rtl/instr_valid_tracker.sv | 28 ++
 rtl/instr_issue_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared state encoding and constants for the instruction issue sequencer
package instr_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_HOLD, S_DONE} state_t;
  localparam int INSTR_TERM = 0;
  localparam int STALL_W = 16;
endpackage

// File: rtl/instr_valid_tracker.sv
// instr_valid_tracker: BS-bit valid vector with set, clear, clear-all and per-index read
// Ports: clear_all wipes every bit; set_en/set_idx marks an entry filled;
// clr_en/clr_idx marks an entry consumed; rd_idx/rd_val reads one bit combinationally.
module instr_valid_tracker #(
  parameter int BS = 16,
  localparam int IDX_W = $clog2(BS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_all,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_val
);
  logic [BS-1:0] v;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) v <= '0;
    else if (clear_all) v <= '0;
    else begin
      if (set_en) v[set_idx] <= 1'b1;
      if (clr_en) v[clr_idx] <= 1'b0;
    end
  end
  assign rd_val = v[rd_idx];
endmodule

// File: rtl/instr_issue_sequencer.sv
// instr_issue_sequencer: fills buffer entries from fetch in order, then issues them in mapping-table order
// Ports: go starts a program; fetch_* is the fetch stream (0 terminates the program);
// buf_* drives the instruction buffer (buf_rdata sampled on leaving RD); map_addr/map_idx query
// the mapping table; issue_* is the valid/ready issue port; map_err is sticky; done pulses at the end.
// Optional: define ISSUE_STALL_CNT_EN to add stall_cnt, a saturating count of stalled issue cycles.
module instr_issue_sequencer
  import instr_seq_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int BS = 16,
  localparam int IDX_W = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               fetch_valid,
  output logic               fetch_ready,
  output logic               buf_we,
  output logic [IDX_W-1:0]   buf_index,
  output logic [INSTR_W-1:0] buf_wdata,
  input  logic [INSTR_W-1:0] buf_rdata,
  output logic [IDX_W-1:0]   map_addr,
  input  logic [IDX_W-1:0]   map_idx,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] issue_instr,
  output logic               map_err,
`ifdef ISSUE_STALL_CNT_EN
  output logic [STALL_W-1:0] stall_cnt,
`endif
  output logic               done
);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(BS - 1);
  state_t state, state_nxt;
  logic [IDX_W:0] fill_cnt, iss_ptr;
  logic term, wr, is_term, in_range, vld_hit, rd_ok, rd_bad, hs, last, batch_end, go_acc, restart;
  always_comb begin
    go_acc = state == S_IDLE && go;
    wr = state == S_FILL && fetch_valid && fetch_instr != INSTR_W'(INSTR_TERM);
    is_term = state == S_FILL && fetch_valid && fetch_instr == INSTR_W'(INSTR_TERM);
    in_range = {1'b0, map_idx} < fill_cnt;
    rd_ok = state == S_RD && in_range && vld_hit;
    rd_bad = state == S_RD && !(in_range && vld_hit);
    hs = issue_valid && issue_ready;
    last = iss_ptr + CNT_ONE == fill_cnt;
    // a skipped final slot completes the batch just like a handshake on it
    batch_end = (hs || rd_bad) && last;
    restart = batch_end && !term;
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = go ? S_FILL : S_IDLE;
      S_FILL: state_nxt = is_term ? (fill_cnt == '0 ? S_DONE : S_RD) : (wr && fill_cnt == CNT_LAST) ? S_RD : S_FILL;
      S_RD: state_nxt = rd_ok ? S_HOLD : batch_end ? (term ? S_DONE : S_FILL) : S_RD;
      S_HOLD: state_nxt = !hs ? S_HOLD : last ? (term ? S_DONE : S_FILL) : S_RD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      fill_cnt <= '0;
      iss_ptr <= '0;
      term <= 1'b0;
      map_err <= 1'b0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
    end else begin
      state <= state_nxt;
      if (go_acc) begin
        fill_cnt <= '0;
        iss_ptr <= '0;
        map_err <= 1'b0;
      end
      if (wr) fill_cnt <= fill_cnt + CNT_ONE;
      if (is_term) term <= 1'b1;
      if (state == S_DONE) term <= 1'b0;
      if (rd_bad) begin
        map_err <= 1'b1;
        iss_ptr <= iss_ptr + CNT_ONE;
      end
      // the buffer read addressed during RD is captured as the RD->HOLD edge
      if (rd_ok) begin
        issue_instr <= buf_rdata;
        issue_valid <= 1'b1;
      end
      if (hs) begin
        issue_valid <= 1'b0;
        iss_ptr <= iss_ptr + CNT_ONE;
      end
      if (restart) begin
        fill_cnt <= '0;
        iss_ptr <= '0;
      end
    end
  end
  instr_valid_tracker #(.BS(BS)) u_vld (
    .clk(clk),
    .rst(rst),
    .clear_all(go_acc || restart),
    .set_en(wr),
    .set_idx(fill_cnt[IDX_W-1:0]),
    .clr_en(rd_ok),
    .clr_idx(map_idx),
    .rd_idx(map_idx),
    .rd_val(vld_hit)
  );
`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (go_acc) stall_cnt <= '0;
    else if (issue_valid && !issue_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
  assign fetch_ready = state == S_FILL;
  assign buf_we = wr;
  assign buf_index = state == S_RD ? map_idx : fill_cnt[IDX_W-1:0];
  assign buf_wdata = fetch_instr;
  assign map_addr = iss_ptr[IDX_W-1:0];
  assign done = state == S_DONE;
endmodule
